// File: rtl/col_sen_pkg.sv
// Shared types and constants for the colour-sensor frame sequencer.
package col_sen_pkg;

    localparam int TIMER_W = 24;
    localparam int NUM_CH  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Filter-select encodings driven on {s2, s3}.
    localparam logic [1:0] CH_RED   = 2'b00;
    localparam logic [1:0] CH_GREEN = 2'b11;
    localparam logic [1:0] CH_CLEAR = 2'b10;
    localparam logic [1:0] CH_BLUE  = 2'b01;

    // Frame order: index 0..3 -> red, green, clear, blue.
    localparam logic [1:0] CH_ORDER [NUM_CH] = '{CH_RED, CH_GREEN, CH_CLEAR, CH_BLUE};

    function automatic logic [1:0] ch_filter(input logic [1:0] idx);
        return CH_ORDER[idx];
    endfunction

endpackage

// File: rtl/col_sen_timer.sv
// Loadable 24-bit down-counter. After a load of N, done_o pulses for one
// cycle N cycles later (N=0 pulses in the first cycle after the load) and
// the counter then parks at zero until the next load; it never wraps.
module col_sen_timer
    import col_sen_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               clear_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               armed_q, armed_d;

    // Next count: load has priority, clear abandons a running count.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load_i) begin
            cnt_d   = load_val_i;
            armed_d = 1'b1;
        end else if (clear_i) begin
            armed_d = 1'b0;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/col_sen_sched.sv
// Colour-sensor frame sequencer: steps the S2/S3 filter through red, green,
// clear, blue, waits the settle time, fires one measurement per channel and
// hands the finished four-count frame to the classifier.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for enable; filter parked at red
//   SETTLE  | filter just changed, settle timer running
//   MEASURE | meas_start issued, waiting for meas_done or timeout
//   PRESENT | frame_valid high, holding frame until frame_ready
module col_sen_sched
    import col_sen_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             s2,
    output logic             s3,
    output logic             meas_start,
    input  logic             meas_done,
    input  logic [CNT_W-1:0] meas_count,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [3:0]       timeout_flags,
    output logic             busy
);

    // Timers count load..0 inclusive, so load one less than the span.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic [1:0]         ch_q;
    logic               s2_q, s3_q;
    logic               meas_start_q;
    logic               frame_valid_q;
    logic [CNT_W-1:0]   out_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]  out_flag_q;
    logic [CNT_W-1:0]   shadow_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]  shadow_flag_q;

    logic               settle_done;
    logic               to_done;
    logic               handshake;
    logic               last_ch;
    logic               go_settle;
    logic               go_measure;
    logic               meas_end;
    logic [1:0]         next_ch;
    logic [CNT_W-1:0]   cap_cnt;
    logic               cap_flag;
    logic [CNT_W-1:0]   frame_cnt [NUM_CH];
    logic [NUM_CH-1:0]  frame_flag;

    // Transition conditions shared by the FSM and the timer load strobes.
    always_comb begin
        handshake  = (state_q == PRESENT) && frame_valid_q && frame_ready;
        last_ch    = (ch_q == 2'd3);
        go_measure = (state_q == SETTLE) && settle_done;
        meas_end   = (state_q == MEASURE) && (meas_done || to_done);
        go_settle  = ((state_q == IDLE) && enable)
                   || (meas_end && !last_ch)
                   || (handshake && enable);
        next_ch    = (state_q == MEASURE) ? ch_q + 2'd1 : 2'd0;
    end

    // Value captured for the current channel; a reply beats a same-cycle timeout.
    // frame_cnt/frame_flag merge it with the shadows so the last channel can
    // go straight to the outputs on the PRESENT entry edge.
    always_comb begin
        cap_cnt  = meas_done ? meas_count : '1;
        cap_flag = !meas_done;
        for (int i = 0; i < NUM_CH; i++) begin
            frame_cnt[i] = (2'(i) == ch_q) ? cap_cnt : shadow_cnt_q[i];
        end
        frame_flag       = shadow_flag_q;
        frame_flag[ch_q] = cap_flag;
    end

    col_sen_timer u_settle_tmr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (go_settle),
        .load_val_i (SETTLE_LOAD),
        .clear_i    (1'b0),
        .done_o     (settle_done)
    );

    col_sen_timer u_timeout_tmr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (go_measure),
        .load_val_i (TIMEOUT_LOAD),
        .clear_i    (meas_end),
        .done_o     (to_done)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_q          <= 2'd0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            meas_start_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            out_flag_q    <= '0;
            shadow_flag_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                out_cnt_q[i]    <= '0;
                shadow_cnt_q[i] <= '0;
            end
        end else begin
            meas_start_q <= go_measure;
            if (go_settle) begin
                ch_q         <= next_ch;
                {s2_q, s3_q} <= ch_filter(next_ch);
            end
            unique case (state_q)
                IDLE: begin
                    if (enable) state_q <= SETTLE;
                end
                SETTLE: begin
                    if (settle_done) state_q <= MEASURE;
                end
                MEASURE: begin
                    if (meas_end) begin
                        shadow_cnt_q[ch_q]  <= cap_cnt;
                        shadow_flag_q[ch_q] <= cap_flag;
                        if (last_ch) begin
                            state_q       <= PRESENT;
                            frame_valid_q <= 1'b1;
                            out_cnt_q     <= frame_cnt;
                            out_flag_q    <= frame_flag;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= enable ? SETTLE : IDLE;
                    end
                end
            endcase
        end
    end

    assign s2            = s2_q;
    assign s3            = s3_q;
    assign meas_start    = meas_start_q;
    assign frame_valid   = frame_valid_q;
    assign red_cnt       = out_cnt_q[0];
    assign green_cnt     = out_cnt_q[1];
    assign clear_cnt     = out_cnt_q[2];
    assign blue_cnt      = out_cnt_q[3];
    assign timeout_flags = out_flag_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_col_sen_sched.sv
// Bench for col_sen_sched: a one-cycle-latency datapath model replies to
// meas_start, expected frames are queued when the blue measurement is
// launched and compared when frame_valid rises.
module tb_col_sen_sched;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset, enable, meas_done, frame_ready;
    logic [CNT_W-1:0] meas_count;
    logic             s2, s3, meas_start, frame_valid, busy;
    logic [CNT_W-1:0] red_cnt, green_cnt, clear_cnt, blue_cnt;
    logic [3:0]       timeout_flags;

    always #5 clk = ~clk;

    col_sen_sched #(
        .CNT_W          (CNT_W),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .s2            (s2),
        .s3            (s3),
        .meas_start    (meas_start),
        .meas_done     (meas_done),
        .meas_count    (meas_count),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .red_cnt       (red_cnt),
        .green_cnt     (green_cnt),
        .clear_cnt     (clear_cnt),
        .blue_cnt      (blue_cnt),
        .timeout_flags (timeout_flags),
        .busy          (busy)
    );

    typedef struct packed {
        logic [3:0][15:0] cnt;
        logic [3:0]       mask;
        logic [3:0][15:0] exp_cnt;
        logic [3:0]       exp_flags;
    } vec_t;

    typedef struct packed {
        logic [3:0][15:0] cnt;
        logic [3:0]       flags;
    } frame_t;

    vec_t        vecs [10];
    frame_t      sb [$];
    logic [1:0]  filt [4];
    int          n_pass = 0, n_checks = 0;
    int          cyc = 0, ms_cnt = 0, frames_seen = 0, ch_idx = 0, fidx = 0;
    int          rise_cyc [16];
    logic        done_pending = 1'b0, stray_req = 1'b0, fv_prev = 1'b0;
    logic [15:0] done_val = '0, stray_val = '0;

    function automatic vec_t mk(input logic [15:0] r, g, c, b, input logic [3:0] m,
                                input logic [15:0] er, eg, ec, eb, input logic [3:0] ef);
        vec_t v;
        v.cnt[0] = r;  v.cnt[1] = g;  v.cnt[2] = c;  v.cnt[3] = b;  v.mask = m;
        v.exp_cnt[0] = er; v.exp_cnt[1] = eg; v.exp_cnt[2] = ec; v.exp_cnt[3] = eb;
        v.exp_flags = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: datapath model, scoreboard push/pop, all sampled 1ns after the edge.
    task automatic tick();
        frame_t e;
        @(posedge clk);
        #1;
        cyc++;
        meas_done = 1'b0;
        if (done_pending) begin
            meas_done = 1'b1; meas_count = done_val; done_pending = 1'b0;
        end
        if (stray_req) begin
            meas_done = 1'b1; meas_count = stray_val; stray_req = 1'b0;
        end
        if (meas_start) begin
            ms_cnt++;
            check("filter_sel", {66'd0, s2, s3}, {66'd0, filt[ch_idx]});
            if (!vecs[fidx].mask[ch_idx]) begin
                done_pending = 1'b1;
                done_val     = vecs[fidx].cnt[ch_idx];
            end
            if (ch_idx == 3) begin
                e.cnt   = vecs[fidx].exp_cnt;
                e.flags = vecs[fidx].exp_flags;
                sb.push_back(e);
                fidx++;
                ch_idx = 0;
            end else begin
                ch_idx++;
            end
        end
        if (frame_valid && !fv_prev) begin
            if (frames_seen < 16) rise_cyc[frames_seen] = cyc;
            frames_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame: frame_valid rose with nothing expected (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("red_cnt",       68'(red_cnt),       68'(e.cnt[0]));
                check("green_cnt",     68'(green_cnt),     68'(e.cnt[1]));
                check("clear_cnt",     68'(clear_cnt),     68'(e.cnt[2]));
                check("blue_cnt",      68'(blue_cnt),      68'(e.cnt[3]));
                check("timeout_flags", 68'(timeout_flags), 68'(e.flags));
            end
        end
        fv_prev = frame_valid;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            tick();
            n++;
        end
        if (frames_seen < target) begin
            n_checks++;
            $display("FAIL %s: timed out, frames seen %0d, required %0d", name, frames_seen, target);
        end
    endtask

    task automatic wait_meas(input int fi, input int ci, input int budget, input string name);
        int n = 0;
        while (!(fidx == fi && ch_idx == ci) && n < budget) begin
            tick();
            n++;
        end
        if (!(fidx == fi && ch_idx == ci)) begin
            n_checks++;
            $display("FAIL %s: timed out at frame %0d ch %0d, required frame %0d ch %0d",
                     name, fidx, ch_idx, fi, ci);
        end
    endtask

    initial begin
        logic [67:0] snap;
        logic [1:0]  s_snap;
        int          ms0, bad, tgt;

        filt[0] = 2'b00; filt[1] = 2'b11; filt[2] = 2'b10; filt[3] = 2'b01;
        vecs[0] = mk(100, 200, 300, 400, 4'b0000, 100, 200, 300, 400, 4'b0000);
        vecs[1] = mk(11, 22, 33, 44, 4'b0000, 11, 22, 33, 44, 4'b0000);
        vecs[2] = mk(500, 600, 700, 800, 4'b0100, 500, 600, 16'hFFFF, 800, 4'b0100);
        vecs[3] = mk(900, 1000, 1100, 1200, 4'b0000, 900, 1000, 1100, 1200, 4'b0000);
        vecs[4] = mk(1, 2, 3, 4, 4'b1001, 16'hFFFF, 2, 3, 16'hFFFF, 4'b1001);
        vecs[5] = mk(0, 16'hFFFF, 7, 8, 4'b0000, 0, 16'hFFFF, 7, 8, 4'b0000);
        vecs[6] = mk(1111, 2222, 3333, 4444, 4'b0000, 1111, 2222, 3333, 4444, 4'b0000);
        vecs[7] = mk(10, 20, 30, 40, 4'b0000, 10, 20, 30, 40, 4'b0000);
        vecs[8] = mk(5, 6, 7, 8, 4'b1000, 5, 6, 7, 16'hFFFF, 4'b1000);
        vecs[9] = mk(4096, 16, 256, 1, 4'b0000, 4096, 16, 256, 1, 4'b0000);

        reset = 1'b1; enable = 1'b0; frame_ready = 1'b0; meas_done = 1'b0; meas_count = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, then enable low for 50 cycles.
        tick();
        check("rst_busy",  68'(busy), 68'(0));
        check("rst_fv",    68'(frame_valid), 68'(0));
        check("rst_cnts",  68'({red_cnt, green_cnt, clear_cnt, blue_cnt, timeout_flags}), 68'(0));
        bad = 0;
        repeat (50) begin
            tick();
            if (busy !== 1'b0 || s2 !== 1'b0 || s3 !== 1'b0 || frame_valid !== 1'b0) bad++;
        end
        check("idle_quiet", 68'(bad), 68'(0));
        check("idle_no_start", 68'(ms_cnt), 68'(0));

        // Table-driven frames back to back with frame_ready high.
        frame_ready = 1'b1;
        enable      = 1'b1;
        for (int i = 0; i < 6; i++) wait_frames(i + 1, 300, "vec_frame");
        check("frame_period", 68'(rise_cyc[1] - rise_cyc[0]), 68'(25));

        // Back-pressure: hold frame 6 for 40 cycles.
        tick();
        frame_ready = 1'b0;
        wait_frames(7, 300, "bp_frame");
        snap   = {red_cnt, green_cnt, clear_cnt, blue_cnt, timeout_flags};
        s_snap = {s2, s3};
        ms0    = ms_cnt;
        bad    = 0;
        repeat (40) begin
            tick();
            if ({red_cnt, green_cnt, clear_cnt, blue_cnt, timeout_flags} !== snap ||
                {s2, s3} !== s_snap || frame_valid !== 1'b1) bad++;
        end
        check("bp_hold", 68'(bad), 68'(0));
        check("bp_no_start", 68'(ms_cnt), 68'(ms0));
        check("bp_filter", 68'({s2, s3}), 68'(2'b01));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("bp_fv_fall", 68'(frame_valid), 68'(0));
        check("bp_restart_busy", 68'(busy), 68'(1));
        check("bp_restart_red", 68'({s2, s3}), 68'(2'b00));
        tick();
        frame_ready = 1'b1;

        // Drop enable during the green measurement of frame 7.
        wait_meas(7, 2, 300, "green_start");
        enable = 1'b0;
        wait_frames(8, 300, "green_frame");
        tick();
        check("stop_busy", 68'(busy), 68'(0));
        check("stop_fv", 68'(frame_valid), 68'(0));
        stray_val = 16'hBEEF;
        stray_req = 1'b1;
        ms0 = ms_cnt;
        repeat (5) tick();
        check("stray_red",   68'(red_cnt),   68'(vecs[7].exp_cnt[0]));
        check("stray_green", 68'(green_cnt), 68'(vecs[7].exp_cnt[1]));
        check("stray_clear", 68'(clear_cnt), 68'(vecs[7].exp_cnt[2]));
        check("stray_blue",  68'(blue_cnt),  68'(vecs[7].exp_cnt[3]));
        check("stray_busy",  68'(busy), 68'(0));
        check("stray_no_start", 68'(ms_cnt), 68'(ms0));

        // Reset while measuring blue (blue reply suppressed so MEASURE persists).
        enable = 1'b1;
        wait_meas(9, 0, 300, "blue_start");
        tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("mr_busy", 68'(busy), 68'(0));
        check("mr_outs", 68'({s2, s3, meas_start, frame_valid}), 68'(0));
        check("mr_cnts", 68'({red_cnt, green_cnt, clear_cnt, blue_cnt, timeout_flags}), 68'(0));
        reset     = 1'b0;
        stray_val = 16'h0BAD;
        stray_req = 1'b1;
        sb.delete();
        repeat (4) tick();
        check("mr_late_done", 68'({red_cnt, green_cnt, clear_cnt, blue_cnt, timeout_flags}), 68'(0));
        check("mr_idle", 68'({busy, frame_valid}), 68'(0));
        tgt    = frames_seen + 1;
        enable = 1'b1;
        wait_frames(tgt, 300, "post_reset_frame");
        enable = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/col_sen_sched.md
Name: col_sen_sched

Overview:
- Sequencer for the TCS3200-style colour sensor front end.
- Drives the S2/S3 filter-select pins through a fixed four-channel frame (red, green, clear, blue) and waits a settle time after each filter change.
- Triggers the separate pulse-measurement datapath once per channel, collects its results and presents one complete frame of four counts to the colour classifier over a valid/ready handshake.

Parameters:
- CNT_W, 16, width of measurement counts and frame outputs.
- SETTLE_CYCLES, 1000, clk cycles from filter change to meas_start; legal range 1 to 2^24-1.
- TIMEOUT_CYCLES, 100000, maximum clk cycles to wait for meas_done after meas_start; legal range 2 to 2^24-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run frames continuously while high.
- s2  out  1  sensor filter select bit S2.
- s3  out  1  sensor filter select bit S3.
- meas_start  out  1  one-cycle pulse; the measurement datapath starts one window.
- meas_done  in  1  one-cycle pulse from the datapath; meas_count is valid this cycle.
- meas_count  in  CNT_W  measured pulse count for the current channel.
- frame_valid  out  1  frame outputs hold a complete, stable frame.
- frame_ready  in  1  the consumer accepts the frame when high together with frame_valid.
- red_cnt, green_cnt, clear_cnt, blue_cnt  out  CNT_W each  per-channel counts of the frame.
- timeout_flags  out  4  bit i set if channel i timed out in this frame; order is [0]=red, [1]=green, [2]=clear, [3]=blue.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, applied in any state including mid-frame:
  - state=IDLE, channel index=0.
  - s2=0, s3=0; meas_start=0; frame_valid=0.
  - All count outputs 0; timeout_flags=0; shadow registers and timers cleared.
  - A meas_done arriving after reset is ignored.
- Channel order and filter encoding {s2,s3}: red=00, green=11, clear=10, blue=01. s2/s3 are registered outputs and change only on entry to SETTLE.
- IDLE:
  - If enable=1, go to SETTLE with channel 0.
  - enable is sampled only in IDLE and on the frame_valid handshake cycle. Deasserting enable mid-frame lets the current frame complete.
- SETTLE:
  - The settle timer is loaded on entry.
  - meas_start pulses on the cycle that is exactly SETTLE_CYCLES cycles after the first SETTLE cycle, and the FSM moves to MEASURE on that same edge.
- MEASURE:
  - The timeout timer starts on the meas_start cycle.
  - On meas_done: meas_count goes to the shadow register of the current channel, and that channel's shadow flag is cleared.
  - If no meas_done arrives within TIMEOUT_CYCLES cycles: the shadow count becomes all-ones and the shadow flag is set.
  - If meas_done and timeout expiry fall in the same cycle, meas_done wins.
  - Then: channel<3 moves to SETTLE with channel+1; channel=3 moves to PRESENT.
  - meas_done outside MEASURE is ignored and modifies nothing.
- PRESENT:
  - On entry, all shadow counts and flags are copied to the outputs in one cycle, and frame_valid rises that cycle.
  - Outputs stay stable while frame_valid=1 and frame_ready=0; no new measurement is started (back-pressure, never overwrite).
  - On the handshake cycle, frame_valid falls the next cycle. The FSM goes to SETTLE with channel 0 if enable=1, otherwise IDLE.
  - Count outputs keep the last frame until the next PRESENT.
- Latency with ideal datapath (meas_done the cycle after meas_start) and frame_ready tied high: frame period = 4*(SETTLE_CYCLES+2)+1 cycles.
- Timers are 24-bit with no wrap; terminal count is detected by equality.

Decomposition:
- Package col_sen_pkg holds:
  - state enum IDLE/SETTLE/MEASURE/PRESENT.
  - channel filter encodings CH_RED=2'b00, CH_GREEN=2'b11, CH_CLEAR=2'b10, CH_BLUE=2'b01.
  - 4-entry channel order table.
  - TIMER_W=24.
- One sub-module, col_sen_timer: loadable down-counter with a done pulse. It is instantiated twice, once for settle and once for timeout.

Test Plan:
- Reset, enable=0 for 50 cycles -> busy=0, s2=s3=0, frame_valid=0, no meas_start pulses.
- SETTLE_CYCLES=4; datapath returns meas_done one cycle after each meas_start with counts 100, 200, 300, 400; frame_ready=1 -> {s2,s3} sequence 00,11,10,01; frame_valid shows red=100, green=200, clear=300, blue=400, timeout_flags=0; period 25 cycles.
- TIMEOUT_CYCLES=16; suppress meas_done for the clear channel only -> clear_cnt=16'hFFFF, timeout_flags=4'b0100, other counts correct. In the next frame, with a reply, the flag returns to 0.
- frame_ready held 0 for 40 cycles after frame_valid -> outputs stable, no meas_start, s2/s3 unchanged; frame_ready=1 for one cycle -> frame_valid=0 the next cycle and a new frame starts at channel 0.
- Deassert enable during the green measurement -> the frame completes, then after the handshake busy=0 in IDLE. A stray meas_done in IDLE -> counts unchanged.
- Assert reset in the MEASURE state of the blue channel -> next cycle all outputs are at reset values; a meas_done one cycle later is ignored; re-enabling starts at red.
